// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared widths and FSM state encodings for the instruction
//            memory loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 16;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_IDLE   = 3'd0;
    localparam state_t c_LEN_HI = 3'd1;
    localparam state_t c_LEN_LO = 3'd2;
    localparam state_t c_DAT_HI = 3'd3;
    localparam state_t c_DAT_LO = 3'd4;
    localparam state_t c_CSUM   = 3'd5;
    localparam state_t c_DONE   = 3'd6;
    localparam state_t c_ERR    = 3'd7;

    // States in which the loader is willing to take a byte from the source.
    function automatic logic takes_bytes(input state_t s);
        return (s == c_LEN_HI) || (s == c_LEN_LO) || (s == c_DAT_HI) ||
               (s == c_DAT_LO) || (s == c_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_csum.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_csum
// Brief    : XOR accumulator over payload bytes; compares the running value
//            against the trailing checksum byte presented on the same bus.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_csum
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_match
);

    logic [BYTE_W-1:0] r_acc;

    // Accumulate payload bytes; a new load reseeds the accumulator with zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_byte;
        end
    end

    assign o_match = (r_acc == i_byte);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Frames a byte stream (16-bit big-endian length header followed
//            by big-endian 16-bit words) into instruction memory writes and
//            holds the core in reset until the load completes.
//            Optional trailing XOR checksum: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    // Comparison width wide enough for both the 16-bit length and the count.
    localparam int CMP_W = ((ADDR_W + 1) > WORD_W) ? (ADDR_W + 2) : (WORD_W + 1);
    localparam logic [CMP_W-1:0]  c_DEPTH_CMP = CMP_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_in_ready;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [WORD_W-1:0]  r_mem_wdata;
    logic [ADDR_W:0]    r_word_count;
    logic [BYTE_W-1:0]  r_len_hi;
    logic [WORD_W-1:0]  r_len;
    logic [BYTE_W-1:0]  r_hi;

    logic               w_hs;
    logic               w_start_load;
    logic [WORD_W-1:0]  w_len;
    logic [CMP_W-1:0]   w_len_cmp;
    logic [CMP_W-1:0]   w_len_reg_cmp;
    logic [CMP_W-1:0]   w_wc_inc_cmp;

    assign w_hs          = in_valid && r_in_ready;
    assign w_start_load  = start && ((r_state == c_IDLE) || (r_state == c_DONE) ||
                                     (r_state == c_ERR));
    assign w_len         = {r_len_hi, in_byte};
    assign w_len_cmp     = CMP_W'(w_len);
    assign w_len_reg_cmp = CMP_W'(r_len);
    assign w_wc_inc_cmp  = CMP_W'(r_word_count) + CMP_W'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Payload end leads to the checksum byte rather than straight to DONE.
    localparam state_t c_AFTER_DATA = c_CSUM;

    logic w_payload_hs;
    logic w_csum_ok;

    assign w_payload_hs = w_hs && ((r_state == c_DAT_HI) || (r_state == c_DAT_LO));

    imem_loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_load),
        .i_en    (w_payload_hs),
        .i_byte  (in_byte),
        .o_match (w_csum_ok)
    );
`else
    localparam state_t c_AFTER_DATA = c_DONE;
`endif

    // State register; in_ready is registered from the next state so it is
    // high exactly while the FSM sits in a byte-accepting state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= takes_bytes(w_next_state);
        end
    end

    // Next-state logic: advance on byte handshakes, start only when not busy.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERR: begin
                if (start) w_next_state = c_LEN_HI;
            end
            c_LEN_HI: begin
                if (w_hs) w_next_state = c_LEN_LO;
            end
            c_LEN_LO: begin
                if (w_hs) begin
                    if (w_len == '0)                    w_next_state = c_AFTER_DATA;
                    else if (w_len_cmp > c_DEPTH_CMP)   w_next_state = c_ERR;
                    else                                w_next_state = c_DAT_HI;
                end
            end
            c_DAT_HI: begin
                if (w_hs) w_next_state = c_DAT_LO;
            end
            c_DAT_LO: begin
                // word_count still excludes the word being handed over now.
                if (w_hs) begin
                    if (w_wc_inc_cmp == w_len_reg_cmp) w_next_state = c_AFTER_DATA;
                    else                               w_next_state = c_DAT_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            c_CSUM: begin
                if (w_hs) w_next_state = w_csum_ok ? c_DONE : c_ERR;
            end
`endif
            default: w_next_state = c_IDLE;
        endcase
    end

    // Datapath: header/data capture, one-cycle write strobe, and address and
    // count advance in the cycle the strobe is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_len_hi     <= '0;
            r_len        <= '0;
            r_hi         <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_load) begin
                r_mem_addr   <= '0;
                r_word_count <= '0;
            end else if (r_mem_we) begin
                // Length is bounded by DEPTH, so this only wraps after the
                // final word of a full-depth load.
                r_mem_addr   <= (r_mem_addr == c_LAST_ADDR) ? '0 : r_mem_addr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_hs) begin
                case (r_state)
                    c_LEN_HI: r_len_hi <= in_byte;
                    c_LEN_LO: r_len    <= w_len;
                    c_DAT_HI: r_hi     <= in_byte;
                    c_DAT_LO: begin
                        r_mem_wdata <= {r_hi, in_byte};
                        r_mem_we    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_word_count;
    assign busy       = !((r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERR));
    assign done       = (r_state == c_DONE);
    assign err        = (r_state == c_ERR);
    // The core is released only in DONE, so leaving DONE re-asserts it at once.
    assign core_rst   = (r_state != c_DONE);

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: fills the core's 16-bit instruction store from a byte stream before execution.
- Frames incoming bytes into a length header plus big-endian 16-bit words, issues one memory write per word, and holds the core in reset until loading completes.
- Sits between a host byte source (UART/debug bridge) and the instruction memory write port, alongside the program counter.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of instruction words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  byte source has a byte on in_byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- core_rst  out  1  holds the core (PC, IR, regs) in reset.
- busy  out  1  load in progress.
- done  out  1  load completed successfully (level).
- err  out  1  load aborted (level).
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, busy=0, done=0, err=0, word_count=0, state=IDLE.
- Byte handshake: a byte transfers on the rising edge where in_valid && in_ready. in_ready is a registered function of state: 1 in LEN_HI, LEN_LO, DAT_HI, DAT_LO (and CSUM); 0 otherwise. in_valid is never dependent on in_ready.
- FSM:
  - IDLE: start -> LEN_HI; clears word_count, mem_addr, done, err; busy=1.
  - LEN_HI: captures len[15:8].
  - LEN_LO: captures len[7:0].
    - len==0 -> DONE (CSUM under the feature).
    - len>DEPTH -> ERR.
    - Otherwise -> DAT_HI.
  - DAT_HI: latches the high byte.
  - DAT_LO: on handshake, registers mem_wdata={hi,lo} and pulses mem_we for exactly one cycle, starting the next cycle, at the current mem_addr. mem_addr and word_count increment the cycle after the write. If word_count+1==len -> DONE (CSUM under the feature), else -> DAT_HI.
  - DONE: busy=0, done=1, core_rst=0.
  - ERR: busy=0, err=1, core_rst=1.
- Write latency: 1 cycle from the low-byte handshake to mem_we. Back-to-back bytes every cycle are supported, so the minimum spacing between writes is 2 cycles.
- Address wrap: mem_addr never exceeds DEPTH-1 because len<=DEPTH is enforced. The last word of a len==DEPTH load lands at DEPTH-1.
- start while busy: ignored.
- start in DONE/ERR: restarts the load; core_rst re-asserts in the same cycle the state leaves DONE; done/err clear.
- start and in_valid in the same cycle in IDLE: only start is acted on; the byte is not accepted (in_ready=0).
- core_rst is 1 in every state except DONE.
- Async rst mid-load: immediate return to reset values. Partially written memory is not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte (or after LEN_LO when len==0), the FSM enters CSUM and accepts one byte.
  - Expected value: XOR of all payload bytes, seeded with 0x00; header bytes excluded.
  - Match -> DONE. Mismatch -> ERR.
  - Words already written remain in memory.
- Undefined: CSUM state and the XOR register are absent; the last data byte goes straight to DONE.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM, DONE, ERR), BYTE_W=8, WORD_W=16.
- One natural sub-module, imem_loader_csum: XOR accumulator with clear/enable/compare. Instantiated only under IMEM_LOADER_CHECKSUM_EN.
- FSM and datapath otherwise stay in imem_loader.

Test Plan:
- Basic load: start, stream 00 02 12 34 AB CD (valid every cycle) -> mem_we at addr 0 data 0x1234, then addr 1 data 0xABCD; done=1, core_rst=0, word_count=2, err=0.
- Throttled source: same stream with in_valid low on random cycles -> identical writes; no duplicate or missing mem_we.
- Length errors:
  - Header 01 01 (257 > DEPTH) -> ERR, err=1, core_rst=1, no mem_we.
  - Header 00 00 -> DONE immediately, word_count=0.
- Abort and restart:
  - rst asserted after 3 payload bytes -> all outputs at reset values asynchronously.
  - Subsequent start plus a full stream loads correctly from addr 0.
- Restart from DONE: after the basic load, start -> core_rst=1 the same cycle, done=0.
  - start pulsed while busy -> no effect on state or counts.
- IMEM_LOADER_CHECKSUM_EN:
  - Stream 00 01 12 34 26 -> DONE.
  - Stream 00 01 12 34 27 -> ERR, err=1, word at addr 0 = 0x1234.
